// File: rtl/data_split_rd.sv
// Read-side gearbox: unpacks a 256-bit AXI-Stream into six 32-bit lanes.
// Lane k carries word 6j+k of the incoming word stream; tlast is checked against PACKET_LENGTH.
module data_split_rd #(
  parameter int PACKET_LENGTH = 16
) (
  input  logic         axis_aclk,
  input  logic         axis_rstb,
  input  logic         axis_tvalid_split,
  output logic         axis_tready_split,
  input  logic         axis_tlast_split,
  input  logic [255:0] axis_tdata_split,
  output logic         axis_tvalid_0,
  output logic         axis_tvalid_1,
  output logic         axis_tvalid_2,
  output logic         axis_tvalid_3,
  output logic         axis_tvalid_4,
  output logic         axis_tvalid_5,
  input  logic         axis_tready_0,
  input  logic         axis_tready_1,
  input  logic         axis_tready_2,
  input  logic         axis_tready_3,
  input  logic         axis_tready_4,
  input  logic         axis_tready_5,
  output logic [31:0]  axis_tdata_0,
  output logic [31:0]  axis_tdata_1,
  output logic [31:0]  axis_tdata_2,
  output logic [31:0]  axis_tdata_3,
  output logic [31:0]  axis_tdata_4,
  output logic [31:0]  axis_tdata_5,
  output logic         tlast_err,
  output logic [15:0]  tlast_err_cnt
);

  typedef enum logic [1:0] {P0 = 2'd0, P2 = 2'd1, P4 = 2'd2, P6 = 2'd3} phase_t;

  localparam logic [7:0] LAST_BEAT = 8'(PACKET_LENGTH - 1);

  phase_t         state_r, state_next_s;
  logic [191:0]   res_r, res_next_s;
  logic [191:0]   frame_r, frame_next_s;
  logic           frame_valid_r;
  logic [5:0]     pending_r;
  logic [7:0]     beat_cnt_r;
  logic           tlast_err_r;
  logic [15:0]    tlast_err_cnt_r;

  logic [5:0]     tready_vec_s;
  logic [5:0]     lane_hs_s;
  logic           slot_free_s;
  logic           in_ready_s;
  logic           in_hs_s;
  logic           load_s;
  logic           mismatch_s;

  assign tready_vec_s = {axis_tready_5, axis_tready_4, axis_tready_3,
                         axis_tready_2, axis_tready_1, axis_tready_0};
  assign lane_hs_s    = pending_r & tready_vec_s & {6{frame_valid_r}};
  // The slot frees in the same cycle the last pending lane takes its word.
  assign slot_free_s  = !frame_valid_r || ((pending_r & ~tready_vec_s) == 6'd0);
  assign in_ready_s   = slot_free_s && (state_r != P6);
  assign in_hs_s      = axis_tvalid_split && in_ready_s;
  assign load_s       = slot_free_s && ((state_r == P6) || in_hs_s);
  assign mismatch_s   = in_hs_s && (axis_tlast_split ? (beat_cnt_r != LAST_BEAT)
                                                     : (beat_cnt_r == LAST_BEAT));

  // Gearbox: frame assembly and residual update per phase.
  always_comb begin
    frame_next_s = 192'd0;
    res_next_s   = res_r;
    state_next_s = state_r;
    case (state_r)
      P0: begin
        frame_next_s = axis_tdata_split[191:0];
        res_next_s   = {128'd0, axis_tdata_split[255:192]};
        state_next_s = P2;
      end
      P2: begin
        frame_next_s = {axis_tdata_split[127:0], res_r[63:0]};
        res_next_s   = {64'd0, axis_tdata_split[255:128]};
        state_next_s = P4;
      end
      P4: begin
        frame_next_s = {axis_tdata_split[63:0], res_r[127:0]};
        res_next_s   = axis_tdata_split[255:64];
        state_next_s = P6;
      end
      P6: begin
        frame_next_s = res_r;
        res_next_s   = 192'd0;
        state_next_s = P0;
      end
      default: begin
        frame_next_s = 192'd0;
        res_next_s   = 192'd0;
        state_next_s = P0;
      end
    endcase
  end

  // Phase and residual registers advance only when a frame loads.
  always_ff @(posedge axis_aclk or negedge axis_rstb) begin
    if (!axis_rstb) begin
      state_r <= P0;
      res_r   <= 192'd0;
    end else if (load_s) begin
      state_r <= state_next_s;
      res_r   <= res_next_s;
    end
  end

  // Output frame register with per-lane pending bits.
  always_ff @(posedge axis_aclk or negedge axis_rstb) begin
    if (!axis_rstb) begin
      frame_r       <= 192'd0;
      frame_valid_r <= 1'b0;
      pending_r     <= 6'd0;
    end else if (load_s) begin
      frame_r       <= frame_next_s;
      frame_valid_r <= 1'b1;
      pending_r     <= 6'b111111;
    end else begin
      pending_r     <= pending_r & ~lane_hs_s;
      frame_valid_r <= frame_valid_r && !slot_free_s;
    end
  end

  // Packet beat counter and tlast mismatch reporting.
  always_ff @(posedge axis_aclk or negedge axis_rstb) begin
    if (!axis_rstb) begin
      beat_cnt_r      <= 8'd0;
      tlast_err_r     <= 1'b0;
      tlast_err_cnt_r <= 16'd0;
    end else begin
      tlast_err_r <= mismatch_s;
      if (in_hs_s) begin
        if (axis_tlast_split || (beat_cnt_r == LAST_BEAT)) begin
          beat_cnt_r <= 8'd0;
        end else begin
          beat_cnt_r <= beat_cnt_r + 8'd1;
        end
      end
      if (mismatch_s && (tlast_err_cnt_r != 16'hFFFF)) begin
        tlast_err_cnt_r <= tlast_err_cnt_r + 16'd1;
      end
    end
  end

  assign axis_tready_split = in_ready_s && axis_rstb;

  assign axis_tvalid_0 = frame_valid_r && pending_r[0];
  assign axis_tvalid_1 = frame_valid_r && pending_r[1];
  assign axis_tvalid_2 = frame_valid_r && pending_r[2];
  assign axis_tvalid_3 = frame_valid_r && pending_r[3];
  assign axis_tvalid_4 = frame_valid_r && pending_r[4];
  assign axis_tvalid_5 = frame_valid_r && pending_r[5];

  assign axis_tdata_0 = frame_r[31:0];
  assign axis_tdata_1 = frame_r[63:32];
  assign axis_tdata_2 = frame_r[95:64];
  assign axis_tdata_3 = frame_r[127:96];
  assign axis_tdata_4 = frame_r[159:128];
  assign axis_tdata_5 = frame_r[191:160];

  assign tlast_err     = tlast_err_r;
  assign tlast_err_cnt = tlast_err_cnt_r;

endmodule

// File: tb/tb_data_split_rd.sv
// Bench for data_split_rd: word-stream scoreboard per lane, a mapping table and directed corner cases.
module tb_data_split_rd;

  logic         clk = 1'b0;
  logic         rstb;
  logic         vin, lin;
  logic [255:0] din;
  logic         rin;
  logic [5:0]   tv, rdy;
  logic [31:0]  td [6];
  logic         terr;
  logic [15:0]  tcnt;

  always #5 clk = ~clk;

  data_split_rd #(.PACKET_LENGTH(16)) dut (
    .axis_aclk(clk), .axis_rstb(rstb),
    .axis_tvalid_split(vin), .axis_tready_split(rin),
    .axis_tlast_split(lin), .axis_tdata_split(din),
    .axis_tvalid_0(tv[0]), .axis_tvalid_1(tv[1]), .axis_tvalid_2(tv[2]),
    .axis_tvalid_3(tv[3]), .axis_tvalid_4(tv[4]), .axis_tvalid_5(tv[5]),
    .axis_tready_0(rdy[0]), .axis_tready_1(rdy[1]), .axis_tready_2(rdy[2]),
    .axis_tready_3(rdy[3]), .axis_tready_4(rdy[4]), .axis_tready_5(rdy[5]),
    .axis_tdata_0(td[0]), .axis_tdata_1(td[1]), .axis_tdata_2(td[2]),
    .axis_tdata_3(td[3]), .axis_tdata_4(td[4]), .axis_tdata_5(td[5]),
    .tlast_err(terr), .tlast_err_cnt(tcnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the word stream since reset, dealt round-robin to six lanes.
  int unsigned exp_q [6][$];
  int          rx_cnt [6];
  int          sidx;
  int unsigned wnext;
  int          pkt_beat;
  bit          err_next;
  int          pulses;
  logic [5:0]  prev_hold;
  logic [31:0] prev_data [6];

  logic        obs_ready;
  logic [5:0]  obs_tv;
  logic [31:0] obs_d [6];
  bit          last_acc;

  typedef struct {
    bit          v;
    bit          exp_ready;
    bit [5:0]    exp_tv;
    int unsigned exp_d0;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mk_beat(input int unsigned w);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = w + i;
    return b;
  endfunction

  task automatic step(input bit v, input bit last, input logic [5:0] r);
    bit err;
    @(negedge clk);
    vin = v; lin = last; rdy = r; din = mk_beat(wnext);
    #1;
    chk("tlast_err_pulse", terr, err_next);
    if (terr) pulses++;
    err_next = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (prev_hold[k]) begin
        chk("hold_valid", tv[k], 1'b1);
        chk("hold_data", td[k], prev_data[k]);
      end
      if (tv[k] && r[k]) begin
        if (exp_q[k].size() == 0) begin
          chk("lane_unexpected_word", {32'd0, td[k]}, 64'hFFFF_FFFF_0000_0000);
        end else begin
          chk($sformatf("lane%0d_data", k), td[k], exp_q[k].pop_front());
        end
        rx_cnt[k]++;
      end
      prev_hold[k] = tv[k] & ~r[k];
      prev_data[k] = td[k];
      obs_d[k] = td[k];
    end
    obs_ready = rin;
    obs_tv = tv;
    last_acc = v && rin;
    if (last_acc) begin
      for (int i = 0; i < 8; i++) begin
        exp_q[sidx % 6].push_back(wnext + i);
        sidx++;
      end
      err = (last != (pkt_beat == 15));
      if (err) err_next = 1'b1;
      pkt_beat = (last || pkt_beat == 15) ? 0 : pkt_beat + 1;
      wnext += 8;
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int unsigned start);
    @(negedge clk);
    rstb = 1'b0; vin = 1'b0; lin = 1'b0;
    #1;
    chk("rst_tvalid", tv, 6'd0);
    chk("rst_tready_split", rin, 1'b0);
    chk("rst_tlast_err", terr, 1'b0);
    chk("rst_err_cnt", tcnt, 16'd0);
    for (int k = 0; k < 6; k++) begin
      exp_q[k].delete();
      rx_cnt[k] = 0;
    end
    sidx = 0; wnext = start; pkt_beat = 0; err_next = 1'b0; pulses = 0; prev_hold = 6'd0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("first_ready", rin, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 6'h3F);
    for (int k = 0; k < 6; k++) chk($sformatf("lane%0d_leftover", k), exp_q[k].size(), 0);
  endtask

  task automatic feed(input int target, inout int n, input logic [5:0] r);
    int guard = 0;
    while (n < target && guard < 400) begin
      step(1'b1, (n % 16) == 15, r);
      if (last_acc) n++;
      guard++;
    end
    chk("feed_beats", n, target);
  endtask

  initial begin
    int n;
    bit pend;
    bit v;
    vin = 1'b0; lin = 1'b0; din = '0; rdy = 6'h3F; rstb = 1'b1;

    tbl[0] = '{v: 1'b1, exp_ready: 1'b1, exp_tv: 6'h00, exp_d0: 0};
    tbl[1] = '{v: 1'b1, exp_ready: 1'b1, exp_tv: 6'h3F, exp_d0: 0};
    tbl[2] = '{v: 1'b1, exp_ready: 1'b1, exp_tv: 6'h3F, exp_d0: 6};
    tbl[3] = '{v: 1'b0, exp_ready: 1'b0, exp_tv: 6'h3F, exp_d0: 12};
    tbl[4] = '{v: 1'b0, exp_ready: 1'b1, exp_tv: 6'h3F, exp_d0: 18};
    tbl[5] = '{v: 1'b0, exp_ready: 1'b1, exp_tv: 6'h00, exp_d0: 0};

    // Word mapping: 24 words 0..23, all lanes ready.
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, 1'b0, 6'h3F);
      chk($sformatf("map_ready_c%0d", i), obs_ready, tbl[i].exp_ready);
      chk($sformatf("map_tvalid_c%0d", i), obs_tv, tbl[i].exp_tv);
      if (tbl[i].exp_tv != 6'h00) begin
        for (int k = 0; k < 6; k++)
          chk($sformatf("map_lane%0d_c%0d", k, i), obs_d[k], tbl[i].exp_d0 + k);
      end
    end
    drain();

    // Long continuous run: 3 packets with correct tlast.
    do_reset(0);
    n = 0;
    feed(48, n, 6'h3F);
    drain();
    for (int k = 0; k < 6; k++) chk($sformatf("long_lane%0d_count", k), rx_cnt[k], 64);
    chk("long_err_cnt", tcnt, 16'd0);

    // Backpressure: lane 3 stalled for 10 cycles mid-stream.
    do_reset(32'h100);
    n = 0;
    feed(5, n, 6'h3F);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 6'h37);
      if (last_acc) n++;
      chk($sformatf("bp_ready_c%0d", i), obs_ready, 1'b0);
      chk($sformatf("bp_tvalid_c%0d", i), obs_tv, (i == 0) ? 6'h3F : 6'h08);
    end
    feed(12, n, 6'h3F);
    drain();

    // Random valid and per-lane ready over 300 beats.
    do_reset(32'h2000);
    n = 0; pend = 1'b0;
    for (int c = 0; c < 6000 && n < 300; c++) begin
      v = pend || ($urandom_range(0, 1) == 1);
      step(v, (n % 16) == 15, 6'($urandom_range(0, 63)));
      if (last_acc) n++;
      pend = v && !last_acc;
    end
    chk("rand_beats", n, 300);
    drain();
    chk("rand_err_cnt", tcnt, 16'd0);

    // Tlast errors: early tlast at beat 9, missing tlast at end of next packet.
    do_reset(32'h3000);
    n = 0;
    for (int c = 0; c < 200 && n < 27; c++) begin
      step(1'b1, n == 9, 6'h3F);
      if (last_acc) n++;
    end
    chk("tl_beats", n, 27);
    drain();
    chk("tl_err_cnt", tcnt, 16'd2);
    chk("tl_pulses", pulses, 2);

    // Reset mid-frame with lane 0 stalled.
    do_reset(0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'h3E);
    do_reset(32'h1000);
    n = 0;
    step(1'b1, 1'b0, 6'h3F);
    if (last_acc) n++;
    step(1'b1, 1'b0, 6'h3F);
    if (last_acc) n++;
    chk("mid_lane0_valid", obs_tv[0], 1'b1);
    chk("mid_lane0_word0", obs_d[0], 32'h1000);
    feed(3, n, 6'h3F);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_split_rd.md
# data_split_rd

Read-side counterpart of the write-path merger. It accepts one 256-bit AXI-Stream (DMA read data, 16-beat packets) and unpacks it into six 32-bit AXI-Stream lanes. Lane k receives 32-bit word index 6j+k of the incoming word stream, for j = 0, 1, 2, … Single clock domain; any clock crossing is placed upstream of this block.

## Interface
- PACKET_LENGTH, 16: expected 256-bit beats per packet, used for the tlast check only.
- axis_aclk  in  1  clock
- axis_rstb  in  1  asynchronous active-low reset
- axis_tvalid_split  in  1  wide stream valid
- axis_tready_split  out  1  wide stream ready
- axis_tlast_split  in  1  packet end marker
- axis_tdata_split  in  256  wide data; word w at bits [32w+31:32w], w = 0 first
- axis_tvalid_k  out  1  lane k valid, k = 0..5
- axis_tready_k  in  1  lane k ready, k = 0..5
- axis_tdata_k  out  32  lane k data, k = 0..5
- tlast_err  out  1  one-cycle pulse on a tlast mismatch
- tlast_err_cnt  out  16  saturating mismatch count

## Operation
- **Gearbox.** Three 256-bit beats (24 words) form four 192-bit frames (6 words each). Residual register res[191:0] holds leftover words. The phase FSM is named by residual word count:
  - P0 (res empty), on input beat b: frame = b[191:0]; res <= b[255:192]; next P2.
  - P2, on beat b: frame = {b[127:0], res[63:0]}; res <= b[255:128]; next P4.
  - P4, on beat b: frame = {b[63:0], res[127:0]}; res <= b[255:64]; next P6.
  - P6: frame = res[191:0]; no input consumed; next P0.
  - Frame word k goes to lane k.
- **Frame register.** Holds frame[191:0], frame_valid, and pending[5:0].
  - On load: pending <= 6'b111111.
  - Lane k handshake clears pending[k].
  - axis_tvalid_k = frame_valid & pending[k]. tvalid never depends on tready.
  - Lanes drain independently. The next frame is not presented to any lane until every lane has taken the current one.
- **Load condition.** slot_free = !frame_valid | ((pending & ~tready_vec) == 0).
  - A frame loads when slot_free and (state == P6 or input handshake).
  - axis_tready_split = slot_free & (state != P6).
  - When nothing loads and the slot drains, frame_valid <= 0.
- **Tlast check.**
  - beat_cnt (8 bits) increments on each input handshake.
  - It returns to 0 after the beat at PACKET_LENGTH-1, or after any beat with tlast = 1.
  - Mismatch: tlast = 1 with beat_cnt != PACKET_LENGTH-1, or tlast = 0 with beat_cnt == PACKET_LENGTH-1.
  - On mismatch: tlast_err pulses for 1 cycle and tlast_err_cnt increments, saturating at 16'hFFFF.
  - The gearbox never realigns on tlast. Packets of 16 beats do not align to frame boundaries; the data stream is continuous.

## Timing
- **Reset values:** state P0, res 0, frame_valid 0, pending 0, all axis_tvalid_k 0, axis_tready_split 0 during reset, beat_cnt 0, tlast_err 0, tlast_err_cnt 0.
- **Reset mid-operation** discards residual words and the pending frame, with no partial emission.
- **First ready:** axis_tready_split = 1 in the first cycle after reset release.
- **Latency:** input handshake at cycle t gives lane tvalid at t+1. The P6 frame is presented the cycle after the P4 frame drains.
- **Throughput with all lanes ready:** one frame per cycle; the input accepts 3 of every 4 cycles (ready low in P6).
- **Simultaneous events:** the last pending lane handshake and the load of the next frame in the same cycle give back-to-back frames with no bubble.
- **Stalled lane:** one lane held not-ready blocks all further frames. Other lanes deassert tvalid after their handshake. Input ready falls in the same cycle.
- **Stability:** the output register holds data and valid stable while ready is low (AXIS rule).

## Test plan
- **Word mapping.** Reset, then send 3 beats with word w = w (0..23), all lanes ready.
  - Lane k receives k, 6+k, 12+k, 18+k on consecutive cycles.
  - axis_tready_split pattern is 1,1,1,0.
- **Long continuous run.** Send 48 beats (3 packets) of an incrementing word count, with tlast at beats 15/31/47.
  - Each lane receives 64 words, all ≡ k mod 6, in order.
  - tlast_err_cnt = 0.
- **Backpressure.** Hold lane 3 ready low for 10 cycles mid-stream, others ready.
  - Lanes ≠ 3 take exactly one word, then drop tvalid.
  - axis_tready_split = 0 throughout.
  - After release, no word is lost or duplicated.
- **Random readies.** Drive random per-lane ready (50%) and random input valid over 300 beats.
  - Per-lane scoreboards match the k mod 6 sequence.
  - tvalid_k never drops without a handshake.
- **Tlast errors.** Put tlast at beat 9, then omit it at beat 15 of the next packet.
  - tlast_err pulses twice; tlast_err_cnt = 2.
  - The data mapping is unaffected.
- **Reset mid-frame.** Assert axis_rstb low after 2 beats with lane 0 stalled.
  - All tvalid_k = 0 and state P0.
  - After release, word 0 of the new stream appears on lane 0.
